aria_key_ctrl: RTL and testbench
================================

// Module: aria_key_ctrl
// PURPOSE
//  Sequencer for the ARIA key register and the shared round-function (RF) datapath.
//  Loads a 128/192/256-bit master key, drives three RF expansion steps to build W0..W3,
//  then issues round-key indices 0..NR to the round-key generator over a valid/ready handshake.
//  Sits between the SPI/host command decoder and the key register + RF datapath.
// PARAMETERS
//  RK_IDX_W    5   width of rk_idx and nr
//  RF_TIMEOUT  64  max cycles waiting for rf_done; 0 = no timeout
// PORTS
//  clk       in   1         clock
//  rst       in   1         reset; synchronous, active-high
//  start     in   1         begin key schedule; sampled in IDLE only
//  ksize     in   2         01=128, 10=192, 11=256; 00 invalid
//  abort     in   1         cancel the schedule and clear the key register
//  key_op    out  2         key register opcode: 00=expand, else set-key size
//  key_en    out  1         key register write enable
//  key_clr   out  1         key register clear
//  rf_go     out  1         one-cycle RF start pulse
//  rf_odd    out  1         1=Fo, 0=Fe round type
//  ck_sel    out  2         CK constant index 1..3
//  rf_done   in   1         RF result (l1) valid this cycle
//  rk_valid  out  1         rk_idx valid
//  rk_ready  in   1         generator accepts rk_idx
//  rk_idx    out  RK_IDX_W  round-key index
//  nr        out  RK_IDX_W  round count: 12/14/16 (128/192/256)
//  busy      out  1         high in every state except IDLE
//  done      out  1         one-cycle pulse after last index accepted
//  err       out  1         one-cycle pulse: invalid ksize or RF timeout
// BEHAVIOUR
//  Reset: state IDLE; every output 0; step, index and timeout counters 0.
//  States: IDLE -> LOAD -> EXP_GO -> EXP_WAIT (x3, step s=0..2) -> GEN -> DONE -> IDLE.
//  IDLE:
//   - start with ksize!=00: latch ksize, set nr, go LOAD.
//   - start with ksize==00: err pulse, stay IDLE, no key writes.
//  LOAD (1 cycle): key_en=1, key_op=ksize.
//  EXP_GO (1 cycle): rf_go=1; rf_odd=(s!=1); ck_sel=((s+ksize-1) mod 3)+1.
//   Sequences: 128 -> 1,2,3; 192 -> 2,3,1; 256 -> 3,1,2.
//  EXP_WAIT: hold rf_odd and ck_sel.
//   - on rf_done: key_en=1, key_op=00 in the same cycle (combinational);
//     s<2 -> EXP_GO with s+1; s==2 -> GEN.
//  GEN: rk_valid=1; rk_idx is stable while !rk_ready.
//   - handshake: rk_idx+1; handshake at rk_idx==nr -> DONE.
//  DONE (1 cycle): done=1, then IDLE. Minimum latency start->done = 9+nr cycles with
//   rf_done returning 1 cycle after rf_go and rk_ready held high.
//  abort (any state, including IDLE): key_clr=1 for 1 cycle, rk_valid and rf_go forced 0,
//   next state IDLE, no done.
//  abort+start in the same cycle: abort wins, start is dropped.
//  rf_done outside EXP_WAIT is ignored. start while busy is ignored.
//  RF_TIMEOUT>0: counter runs in EXP_WAIT; on reaching RF_TIMEOUT -> err pulse, key_clr pulse, IDLE.
//  rst in mid-schedule returns to IDLE with outputs 0; no key_clr is issued.
// CONFIGURATION
//  ARIA_KEY_CTRL_DEC_EN defined:
//   - adds input port dec (1b), latched at start;
//   - dec=1: GEN issues rk_idx nr, nr-1 .. 0 and exits after index 0; dec=0 as below.
//  Undefined: no dec port; GEN always counts 0..nr.
// STRUCTURE
//  aria_key_pkg (header): KEY_EXPAND/KEY_SET_* opcodes, NR_128/192/256, state encoding.
//  Single module; CK rotation and nr lookup are small combinational functions. No sub-module.
// TESTING
//  - 128: start,ksize=01, rf_done 1 cycle after each rf_go ->
//    LOAD op=01; ck_sel 1,2,3; rf_odd 1,0,1; rk_idx 0..12; done once.
//  - 256 with rk_ready toggling every other cycle -> ck_sel 3,1,2; rk_idx 0..16 with no skips or
//    repeats; rk_idx stable while stalled.
//  - start,ksize=00 -> err=1 for one cycle; key_en never asserted; busy stays 0.
//  - abort in the cycle of the 2nd rf_done -> key_clr 1 cycle, no key_en that cycle, IDLE, no done.
//  - RF_TIMEOUT=8, rf_done withheld -> err and key_clr 8 cycles after entering EXP_WAIT.
//  - DEC_EN, 192, dec=1 -> ck_sel 2,3,1; rk_idx 14 down to 0; then done.

Source files
------------

// File: rtl/aria_key_pkg.sv
// Shared encodings for the ARIA key sequencer: key-register opcodes, round counts
// and the controller state encoding.
package aria_key_pkg;

    localparam logic [1:0] KEY_EXPAND  = 2'b00;
    localparam logic [1:0] KEY_SET_128 = 2'b01;
    localparam logic [1:0] KEY_SET_192 = 2'b10;
    localparam logic [1:0] KEY_SET_256 = 2'b11;

    localparam int NR_128 = 12;
    localparam int NR_192 = 14;
    localparam int NR_256 = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXP_GO,
        ST_EXP_WAIT,
        ST_GEN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/aria_key_ctrl.sv
// ARIA key-schedule sequencer: master-key load, three RF expansion steps, round-key index issue.
// Optional ARIA_KEY_CTRL_DEC_EN adds a dec input that makes GEN count nr down to 0.
module aria_key_ctrl
    import aria_key_pkg::*;
#(
    parameter int RK_IDX_W   = 5,
    parameter int RF_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          ksize,
    input  logic                abort,
`ifdef ARIA_KEY_CTRL_DEC_EN
    input  logic                dec,
`endif
    output logic [1:0]          key_op,
    output logic                key_en,
    output logic                key_clr,
    output logic                rf_go,
    output logic                rf_odd,
    output logic [1:0]          ck_sel,
    input  logic                rf_done,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [RK_IDX_W-1:0] rk_idx,
    output logic [RK_IDX_W-1:0] nr,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int TMO_W = (RF_TIMEOUT > 0) ? $clog2(RF_TIMEOUT + 1) : 1;

    state_e              state_q, state_d;
    logic [1:0]          ksize_q, ksize_d;
    logic [RK_IDX_W-1:0] nr_q, nr_d;
    logic [1:0]          step_q, step_d;
    logic [RK_IDX_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                cnt_down;
    logic [RK_IDX_W-1:0] last_idx;

`ifdef ARIA_KEY_CTRL_DEC_EN
    logic dec_q, dec_d;
    assign cnt_down = dec_q;
`else
    assign cnt_down = 1'b0;
`endif

    // CK index rotates with key size: step s uses CK((s + ksize - 1) mod 3) + 1.
    function automatic logic [1:0] ck_rot(input logic [1:0] s, input logic [1:0] ks);
        logic [2:0] sum;
        logic [2:0] r;
        sum = {1'b0, s} + {1'b0, ks} - 3'd1;
        r   = (sum >= 3'd3) ? sum - 3'd3 : sum;
        return r[1:0] + 2'd1;
    endfunction

    function automatic logic [RK_IDX_W-1:0] nr_of(input logic [1:0] ks);
        case (ks)
            KEY_SET_128: return RK_IDX_W'(NR_128);
            KEY_SET_192: return RK_IDX_W'(NR_192);
            default:     return RK_IDX_W'(NR_256);
        endcase
    endfunction

    assign last_idx = cnt_down ? '0 : nr_q;
    assign nr       = nr_q;

    always_comb begin
        state_d  = state_q;
        ksize_d  = ksize_q;
        nr_d     = nr_q;
        step_d   = step_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
`ifdef ARIA_KEY_CTRL_DEC_EN
        dec_d    = dec_q;
`endif
        key_op   = KEY_EXPAND;
        key_en   = 1'b0;
        key_clr  = 1'b0;
        rf_go    = 1'b0;
        rf_odd   = 1'b0;
        ck_sel   = 2'd0;
        rk_valid = 1'b0;
        rk_idx   = '0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;

        // Outputs are held quiet while reset is asserted so a reset never looks like a clear.
        if (!rst) begin
            busy = (state_q != ST_IDLE);
            if (abort) begin
                key_clr = 1'b1;
                state_d = ST_IDLE;
                step_d  = 2'd0;
                idx_d   = '0;
                tmo_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (ksize != 2'b00) begin
                                ksize_d = ksize;
                                nr_d    = nr_of(ksize);
                                step_d  = 2'd0;
`ifdef ARIA_KEY_CTRL_DEC_EN
                                dec_d   = dec;
`endif
                                state_d = ST_LOAD;
                            end else begin
                                err = 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        key_en  = 1'b1;
                        key_op  = ksize_q;
                        state_d = ST_EXP_GO;
                    end
                    ST_EXP_GO: begin
                        rf_go   = 1'b1;
                        rf_odd  = (step_q != 2'd1);
                        ck_sel  = ck_rot(step_q, ksize_q);
                        tmo_d   = '0;
                        state_d = ST_EXP_WAIT;
                    end
                    ST_EXP_WAIT: begin
                        rf_odd = (step_q != 2'd1);
                        ck_sel = ck_rot(step_q, ksize_q);
                        if (rf_done) begin
                            key_en = 1'b1;
                            key_op = KEY_EXPAND;
                            if (step_q == 2'd2) begin
                                idx_d   = cnt_down ? nr_q : '0;
                                state_d = ST_GEN;
                            end else begin
                                step_d  = step_q + 2'd1;
                                state_d = ST_EXP_GO;
                            end
                        end else if (RF_TIMEOUT > 0) begin
                            if (tmo_q == TMO_W'(RF_TIMEOUT)) begin
                                err     = 1'b1;
                                key_clr = 1'b1;
                                step_d  = 2'd0;
                                state_d = ST_IDLE;
                            end else begin
                                tmo_d = tmo_q + TMO_W'(1);
                            end
                        end
                    end
                    ST_GEN: begin
                        rk_valid = 1'b1;
                        rk_idx   = idx_q;
                        if (rk_ready) begin
                            if (idx_q == last_idx) begin
                                state_d = ST_DONE;
                            end else if (cnt_down) begin
                                idx_d = idx_q - RK_IDX_W'(1);
                            end else begin
                                idx_d = idx_q + RK_IDX_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        done    = 1'b1;
                        step_d  = 2'd0;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ksize_q <= 2'b00;
            nr_q    <= '0;
            step_q  <= 2'd0;
            idx_q   <= '0;
            tmo_q   <= '0;
`ifdef ARIA_KEY_CTRL_DEC_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ksize_q <= ksize_d;
            nr_q    <= nr_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
`ifdef ARIA_KEY_CTRL_DEC_EN
            dec_q   <= dec_d;
`endif
        end
    end

endmodule

// File: tb/tb_aria_key_ctrl.sv
// Scoreboard bench for aria_key_ctrl: driver queues expected key/RF/index events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_aria_key_ctrl;

    localparam int RK_IDX_W = 5;

    localparam int EV_CLR  = 1;
    localparam int EV_KEY  = 2;
    localparam int EV_RF   = 3;
    localparam int EV_IDX  = 4;
    localparam int EV_DONE = 5;
    localparam int EV_ERR  = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          ksize = 2'b00;
    logic                abort = 1'b0;
`ifdef ARIA_KEY_CTRL_DEC_EN
    logic                dec = 1'b0;
`endif
    logic [1:0]          key_op;
    logic                key_en, key_clr, rf_go, rf_odd;
    logic [1:0]          ck_sel;
    logic                rf_done = 1'b0;
    logic                rk_valid;
    logic                rk_ready = 1'b0;
    logic [RK_IDX_W-1:0] rk_idx, nr;
    logic                busy, done, err;

    int q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = -1;
    int err_cyc = -1;
    int start_cyc = 0;
    int wait_cyc = 0;
    logic prev_stall = 1'b0;
    logic [RK_IDX_W-1:0] prev_idx = '0;

    aria_key_ctrl #(.RK_IDX_W(RK_IDX_W), .RF_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ksize(ksize), .abort(abort),
`ifdef ARIA_KEY_CTRL_DEC_EN
        .dec(dec),
`endif
        .key_op(key_op), .key_en(key_en), .key_clr(key_clr), .rf_go(rf_go),
        .rf_odd(rf_odd), .ck_sel(ck_sel), .rf_done(rf_done), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .rk_idx(rk_idx), .nr(nr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ev(input int got);
        int e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got type %0d val %0d expected none (cycle %0d)",
                     got / 256, got % 256, cyc);
        end else begin
            e = q.pop_front();
            check("event", got, e);
        end
    endtask

    // Monitor: one event per active output; same-cycle events in fixed order.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_clr) ev(EV_CLR * 256);
            if (key_en) ev(EV_KEY * 256 + int'(key_op));
            if (rf_go) ev(EV_RF * 256 + int'(ck_sel) * 2 + int'(rf_odd));
            if (rk_valid && rk_ready) ev(EV_IDX * 256 + int'(rk_idx));
            if (done) begin
                ev(EV_DONE * 256);
                done_cyc = cyc;
            end
            if (err) begin
                ev(EV_ERR * 256);
                err_cyc = cyc;
            end
            if (prev_stall && rk_valid) check("idx_stable", int'(rk_idx), int'(prev_idx));
            prev_stall <= rk_valid && !rk_ready;
            prev_idx   <= rk_idx;
        end
    end

    task automatic exp_ev(input int t, input int v);
        q.push_back(t * 256 + v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expand(input int ks, input int c1, input int c2, input int c3);
        exp_ev(EV_KEY, ks);
        exp_ev(EV_RF, c1 * 2 + 1);
        exp_ev(EV_KEY, 0);
        exp_ev(EV_RF, c2 * 2 + 0);
        exp_ev(EV_KEY, 0);
        exp_ev(EV_RF, c3 * 2 + 1);
        exp_ev(EV_KEY, 0);
    endtask

    task automatic do_start(input logic [1:0] ks, input logic d);
        start = 1'b1;
        ksize = ks;
`ifdef ARIA_KEY_CTRL_DEC_EN
        dec = d;
`else
        if (d) $display("note: dec ignored in this build");
`endif
        start_cyc = cyc;
        tick();
        start = 1'b0;
        ksize = 2'b00;
    endtask

    // From LOAD: three EXP_GO/EXP_WAIT pairs with rf_done one cycle after rf_go.
    task automatic run_expand();
        tick();
        for (int s = 0; s < 3; s++) begin
            tick();
            rf_done = 1'b1;
            tick();
            rf_done = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        check(name, int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({key_op, key_en, key_clr, rf_go, rf_odd, ck_sel, rk_valid,
                                      rk_idx, nr, busy, done, err}), 0);
        #1;
        rst = 1'b0;
        tick();
        check("idle_busy", int'(busy), 0);

        // 128-bit key, ready always high, minimum latency
        push_expand(1, 1, 2, 3);
        for (int i = 0; i <= 12; i++) exp_ev(EV_IDX, i);
        exp_ev(EV_DONE, 0);
        rk_ready = 1'b1;
        do_start(2'b01, 1'b0);
        check("busy_load", int'(busy), 1);
        run_expand();
        wait_idle("idle_128", 40);
        check("latency_128", done_cyc - start_cyc, 21);
        check("nr_128", int'(nr), 12);

        // 256-bit key, rk_ready toggling
        push_expand(3, 3, 1, 2);
        for (int i = 0; i <= 16; i++) exp_ev(EV_IDX, i);
        exp_ev(EV_DONE, 0);
        rk_ready = 1'b0;
        do_start(2'b11, 1'b0);
        run_expand();
        for (int i = 0; i < 80; i++) begin
            if (!busy) break;
            rk_ready = ~rk_ready;
            tick();
        end
        rk_ready = 1'b1;
        wait_idle("idle_256", 4);
        check("nr_256", int'(nr), 16);

        // invalid key size
        exp_ev(EV_ERR, 0);
        do_start(2'b00, 1'b0);
        check("err_cycle", err_cyc, start_cyc);
        check("busy_invalid", int'(busy), 0);
        repeat (3) tick();
        check("busy_invalid_later", int'(busy), 0);

        // abort in the cycle of the second rf_done
        exp_ev(EV_KEY, 1);
        exp_ev(EV_RF, 1 * 2 + 1);
        exp_ev(EV_KEY, 0);
        exp_ev(EV_RF, 2 * 2 + 0);
        exp_ev(EV_CLR, 0);
        done_cyc = -1;
        do_start(2'b01, 1'b0);
        tick();
        tick();
        rf_done = 1'b1;
        tick();
        rf_done = 1'b0;
        tick();
        rf_done = 1'b1;
        abort = 1'b1;
        tick();
        rf_done = 1'b0;
        abort = 1'b0;
        check("busy_after_abort", int'(busy), 0);
        repeat (4) tick();
        check("no_done_after_abort", done_cyc, -1);

        // abort and start together in IDLE
        exp_ev(EV_CLR, 0);
        abort = 1'b1;
        do_start(2'b01, 1'b0);
        abort = 1'b0;
        check("busy_abort_start", int'(busy), 0);

        // RF timeout with rf_done withheld
        exp_ev(EV_KEY, 1);
        exp_ev(EV_RF, 1 * 2 + 1);
        exp_ev(EV_CLR, 0);
        exp_ev(EV_ERR, 0);
        do_start(2'b01, 1'b0);
        tick();
        tick();
        wait_cyc = cyc;
        wait_idle("idle_timeout", 30);
        check("timeout_cycles", err_cyc - wait_cyc, 8);

        // reset in mid-schedule: no clear, outputs quiet
        exp_ev(EV_KEY, 1);
        exp_ev(EV_RF, 1 * 2 + 1);
        do_start(2'b01, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_outputs", int'({key_op, key_en, key_clr, rf_go, rf_odd, ck_sel, rk_valid,
                                        rk_idx, nr, busy, done, err}), 0);
        repeat (3) tick();

        // 192-bit key counting up
        push_expand(2, 2, 3, 1);
        for (int i = 0; i <= 14; i++) exp_ev(EV_IDX, i);
        exp_ev(EV_DONE, 0);
        do_start(2'b10, 1'b0);
        run_expand();
        wait_idle("idle_192", 40);
        check("nr_192", int'(nr), 14);

`ifdef ARIA_KEY_CTRL_DEC_EN
        // 192-bit key counting down
        push_expand(2, 2, 3, 1);
        for (int i = 14; i >= 0; i--) exp_ev(EV_IDX, i);
        exp_ev(EV_DONE, 0);
        do_start(2'b10, 1'b1);
        run_expand();
        wait_idle("idle_192_dec", 40);
`endif

        repeat (5) tick();
        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
